// File: rtl/psram_burst_model_if.sv
// Command, write-beat and read-beat signals of the PSRAM HS user port.
// The master drives commands and write data; the slave (memory model) returns read beats and status.
interface psram_burst_model_if #(
    parameter int ADDR_WIDTH = 21,
    parameter int DATA_WIDTH = 64
);
    logic                    cmd_en;
    logic                    cmd;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] data_mask;
    logic [DATA_WIDTH-1:0]   rd_data;
    logic                    rd_data_valid;
    logic                    init_calib;
    logic                    busy;
    logic                    cmd_err;

    modport master (
        output cmd_en, cmd, addr, wr_data, data_mask,
        input  rd_data, rd_data_valid, init_calib, busy, cmd_err
    );

    modport slave (
        input  cmd_en, cmd, addr, wr_data, data_mask,
        output rd_data, rd_data_valid, init_calib, busy, cmd_err
    );
endinterface

// File: rtl/psram_burst_model.sv
// Cycle-level PSRAM HS model: init calibration, wrapped bursts, byte masks, RD_LAT read latency, TCMD spacing.
// Commands during INIT or while busy are dropped and flag the sticky cmd_err; there is no other backpressure.
module psram_burst_model #(
    parameter int ADDR_WIDTH  = 21,
    parameter int DATA_WIDTH  = 64,
    parameter int BURST_BEATS = 8,
    parameter int TCMD        = 38,
    parameter int RD_LAT      = 30,
    parameter int INIT_CYCLES = 3000
) (
    input logic                clk,
    input logic                rst,
    psram_burst_model_if.slave bus
);
    localparam int L        = $clog2(BURST_BEATS);
    localparam int NBYTES   = DATA_WIDTH / 8;
    localparam int RD_END   = (TCMD > RD_LAT + BURST_BEATS) ? TCMD : RD_LAT + BURST_BEATS;
    localparam int CNT_MAX  = (RD_END > INIT_CYCLES) ? RD_END : INIT_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 2);
    localparam int DEPTH    = 1 << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WRITE,
        S_READ,
        S_GAP
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [CW-1:0]           cnt;
    logic [CW-1:0]           cnt_nxt;
    logic [CW-1:0]           cnt_inc;
    logic                    cmd_lat;
    logic [ADDR_WIDTH-1:0]   addr_lat;
    logic                    accept;
    logic                    cmd_viol;
    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic                    rd_load;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [DATA_WIDTH-1:0]   rd_dat;
    logic                    rd_vld;
    logic                    err;

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

    // Wrapped burst: upper address bits stay fixed, low L bits step modulo BURST_BEATS.
    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [CW-1:0]         beat);
        logic [ADDR_WIDTH-1:0] a;
        a        = base;
        a[L-1:0] = base[L-1:0] + beat[L-1:0];
        return a;
    endfunction

    // The counter holds the index of the current cycle within a burst (or init), saturating.
    assign cnt_inc  = (cnt == {CW{1'b1}}) ? cnt : cnt + 1'b1;
    assign accept   = bus.cmd_en && (state == S_IDLE);
    assign cmd_viol = bus.cmd_en && (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_inc;
        wr_en     = 1'b0;
        wr_addr   = addr_lat;
        rd_load   = 1'b0;
        rd_addr   = addr_lat;
        case (state)
            S_INIT: begin
                if (cnt == CW'(INIT_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                if (accept) begin
                    cnt_nxt = CW'(1);
                    if (bus.cmd) begin
                        // Beat 0 of a write is taken on the accept edge itself.
                        wr_en     = 1'b1;
                        wr_addr   = bus.addr;
                        state_nxt = S_WRITE;
                    end else begin
                        rd_load   = (RD_LAT == 1);
                        rd_addr   = bus.addr;
                        state_nxt = S_READ;
                    end
                end
            end
            S_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = beat_addr(addr_lat, cnt);
                if (cnt == CW'(BURST_BEATS - 1)) begin
                    state_nxt = (cnt_inc == CW'(TCMD)) ? S_IDLE : S_GAP;
                end
            end
            S_READ: begin
                // Load the beat that will be presented in the next cycle.
                if ((cnt_inc >= CW'(RD_LAT)) && (cnt_inc <= CW'(RD_LAT + BURST_BEATS - 1))) begin
                    rd_load = 1'b1;
                    rd_addr = beat_addr(addr_lat, cnt_inc - CW'(RD_LAT));
                end
                if (cnt_inc == CW'(RD_LAT + BURST_BEATS - 1)) begin
                    state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_inc == (cmd_lat ? CW'(TCMD) : CW'(RD_END))) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_INIT;
            cnt      <= '0;
            cmd_lat  <= 1'b0;
            addr_lat <= '0;
            rd_dat   <= '0;
            rd_vld   <= 1'b0;
            err      <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rd_vld <= rd_load;
            rd_dat <= rd_load ? mem[rd_addr] : '0;
            if (accept) begin
                cmd_lat  <= bus.cmd;
                addr_lat <= bus.addr;
            end
            if (cmd_viol) begin
                err <= 1'b1;
            end
        end
    end

    // The array has no reset so its contents survive a mid-run rst.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (!bus.data_mask[b]) begin
                    mem[wr_addr][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign bus.rd_data       = rd_dat;
    assign bus.rd_data_valid = rd_vld;
    assign bus.init_calib    = (state != S_INIT);
    assign bus.busy          = (state == S_WRITE) || (state == S_READ) || (state == S_GAP);
    assign bus.cmd_err       = err;
endmodule

// File: tb/tb_psram_burst_model.sv
// Directed bench for psram_burst_model: burst table applied back-to-back, plus init, spacing and mid-burst reset sequences.
module tb_psram_burst_model;
    localparam int AW   = 10;
    localparam int DW   = 64;
    localparam int BB   = 4;
    localparam int TC   = 12;
    localparam int RL   = 6;
    localparam int IC   = 20;
    localparam int ENDC = 12;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] HALF = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic             wr;
        logic [AW-1:0]    addr;
        logic [3:0][63:0] dat;   // beat 0 in the low word
        logic [3:0][7:0]  msk;
        logic [3:0][63:0] exp;
    } op_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    op_t  ops [8];

    psram_burst_model_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    psram_burst_model #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .BURST_BEATS(BB),
        .TCMD       (TC),
        .RD_LAT     (RL),
        .INIT_CYCLES(IC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "timeout");
    end

    function automatic op_t mk(input logic wr, input logic [AW-1:0] a, input logic [255:0] d,
                               input logic [31:0] m, input logic [255:0] e);
        op_t o;
        o.wr   = wr;
        o.addr = a;
        o.dat  = d;
        o.msk  = m;
        o.exp  = e;
        return o;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.cmd_en    = 1'b0;
        bus.cmd       = 1'b0;
        bus.addr      = '0;
        bus.wr_data   = JUNK;
        bus.data_mask = '0;
    endtask

    // Called at the negedge of the accept cycle; returns at the negedge of cycle ENDC,
    // where the next command may be issued. inj>0 drives an illegal write in cycle inj.
    task automatic run_burst(input op_t op, input string tag, input logic err_in, input int inj);
        logic exp_v;
        logic exp_e;
        for (int p = 0; p <= ENDC; p++) begin
            exp_v = !op.wr && (p >= RL) && (p < RL + BB);
            exp_e = err_in || ((inj > 0) && (p > inj));
            check($sformatf("%s busy c%0d", tag, p), 64'(bus.busy), 64'((p > 0) && (p < ENDC)));
            check($sformatf("%s valid c%0d", tag, p), 64'(bus.rd_data_valid), 64'(exp_v));
            check($sformatf("%s data c%0d", tag, p), bus.rd_data, exp_v ? op.exp[p-RL] : 64'h0);
            check($sformatf("%s err c%0d", tag, p), 64'(bus.cmd_err), 64'(exp_e));
            idle_inputs();
            if (p == 0) begin
                bus.cmd_en = 1'b1;
                bus.cmd    = op.wr;
                bus.addr   = op.addr;
            end
            if (op.wr && p < BB) begin
                bus.wr_data   = op.dat[p];
                bus.data_mask = op.msk[p];
            end
            if ((inj > 0) && (p == inj)) begin
                bus.cmd_en  = 1'b1;
                bus.cmd     = 1'b1;
                bus.addr    = 10'h006;
                bus.wr_data = JUNK;
            end
            if (p < ENDC) @(negedge clk);
        end
        idle_inputs();
    endtask

    initial begin
        ops[0] = mk(1'b1, 10'h006, {64'hA3, 64'hA2, 64'hA1, 64'hA0}, 32'h0, '0);
        ops[1] = mk(1'b0, 10'h004, '0, 32'h0, {64'hA1, 64'hA0, 64'hA3, 64'hA2});
        ops[2] = mk(1'b1, 10'h010, {ONES, ONES, ONES, ONES}, 32'h0, '0);
        ops[3] = mk(1'b1, 10'h010, '0, 32'hFFFF_FF0F, '0);
        ops[4] = mk(1'b0, 10'h010, '0, 32'h0, {ONES, ONES, ONES, HALF});
        ops[5] = mk(1'b0, 10'h013, '0, 32'h0, {ONES, ONES, HALF, ONES});
        ops[6] = mk(1'b1, 10'h3FD, {64'h44, 64'h33, 64'h22, 64'h11}, 32'h0, '0);
        ops[7] = mk(1'b0, 10'h3FC, '0, 32'h0, {64'h33, 64'h22, 64'h11, 64'h44});

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset init_calib", 64'(bus.init_calib), 64'h0);
        check("reset busy", 64'(bus.busy), 64'h0);
        check("reset valid", 64'(bus.rd_data_valid), 64'h0);
        check("reset data", bus.rd_data, 64'h0);
        check("reset err", 64'(bus.cmd_err), 64'h0);

        // Init: rst is first sampled low at the end of cycle 0.
        for (int c = 0; c <= IC; c++) begin
            if (c == 0) rst = 1'b0;
            check($sformatf("init calib c%0d", c), 64'(bus.init_calib), 64'(c >= IC));
            check($sformatf("init busy c%0d", c), 64'(bus.busy), 64'h0);
            check($sformatf("init err c%0d", c), 64'(bus.cmd_err), 64'h0);
            if (c < IC) @(negedge clk);
        end

        // Table ops issued back-to-back, each accepted exactly TCMD cycles after the previous one.
        for (int i = 0; i < 8; i++) begin
            run_burst(ops[i], $sformatf("op%0d", i), 1'b0, 0);
        end

        // Spacing violation five cycles into a read; first burst and memory stay intact.
        run_burst(ops[1], "spacing rd", 1'b0, 5);
        run_burst(mk(1'b0, 10'h006, '0, 32'h0, {64'hA3, 64'hA2, 64'hA1, 64'hA0}), "spacing chk", 1'b1, 0);

        // Reset during read beat 1, then a command during the rerun INIT.
        for (int c = 0; c <= 8; c++) begin
            idle_inputs();
            if (c == 0) begin
                bus.cmd_en = 1'b1;
                bus.addr   = 10'h004;
            end
            if (c == RL) check("rst beat0 data", bus.rd_data, 64'hA2);
            if (c == RL + 1) begin
                check("rst beat1 valid", 64'(bus.rd_data_valid), 64'h1);
                check("rst beat1 data", bus.rd_data, 64'hA3);
                rst = 1'b1;
            end
            if (c == RL + 2) begin
                check("rst valid drop", 64'(bus.rd_data_valid), 64'h0);
                check("rst data zero", bus.rd_data, 64'h0);
                check("rst busy", 64'(bus.busy), 64'h0);
                check("rst calib", 64'(bus.init_calib), 64'h0);
                check("rst err clear", 64'(bus.cmd_err), 64'h0);
                rst = 1'b0;
            end
            if (c < 8) @(negedge clk);
        end
        for (int c = 0; c <= IC; c++) begin
            check($sformatf("reinit calib c%0d", c), 64'(bus.init_calib), 64'(c >= IC));
            check($sformatf("reinit busy c%0d", c), 64'(bus.busy), 64'h0);
            check($sformatf("reinit err c%0d", c), 64'(bus.cmd_err), 64'(c > 10));
            idle_inputs();
            if (c == 10) begin
                bus.cmd_en  = 1'b1;
                bus.cmd     = 1'b1;
                bus.addr    = 10'h004;
                bus.wr_data = JUNK;
            end
            if (c < IC) @(negedge clk);
        end
        run_burst(ops[1], "post rst rd004", 1'b1, 0);
        run_burst(ops[4], "post rst rd010", 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
